// File: rtl/timer_cmp_irq_pkg.sv
// Shared register map, CTRL bit layout and defaults for the timer compare/interrupt unit.
package timer_cmp_irq_pkg;
  localparam logic [2:0] ADDR_NOW_LO = 3'd0;
  localparam logic [2:0] ADDR_NOW_HI = 3'd1;
  localparam logic [2:0] ADDR_CMP_LO = 3'd2;
  localparam logic [2:0] ADDR_CMP_HI = 3'd3;
  localparam logic [2:0] ADDR_CTRL   = 3'd4;
  localparam logic [2:0] ADDR_PERIOD = 3'd5;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_PER  = 1;
  localparam int CTRL_PEND = 2;

  localparam logic [63:0] CMP_RESET_DEFAULT = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic pending;
    logic periodic;
    logic enable;
  } ctrl_t;
endpackage

// File: rtl/timer_cmp_irq_now_sampler.sv
// Stability filter on the timer count: now_s only accepts a value seen on two consecutive samples.
module now_sampler (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] now,
  output logic [63:0] now_s
);
  logic [63:0] now_q, now_q_d;
  logic [63:0] now_s_q, now_s_d;

  always_comb begin
    now_q_d = now;
    now_s_d = now_s_q;
    // now is produced on another clock; a value that differs from the last sample may be mid-update
    if (now == now_q) now_s_d = now_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      now_q   <= '0;
      now_s_q <= '0;
    end else begin
      now_q   <= now_q_d;
      now_s_q <= now_s_d;
    end
  end

  assign now_s = now_s_q;
endmodule

// File: rtl/timer_cmp_irq.sv
// 64-bit compare/interrupt unit on a 32-bit register bus; one-shot or auto-reload compare,
// tear-free NOW reads via a high-word snapshot, and a stretched clear pulse back to the timer.
module timer_cmp_irq
  import timer_cmp_irq_pkg::*;
#(
  parameter int          CLR_CYCLES = 2,
  parameter logic [63:0] CMP_RESET  = CMP_RESET_DEFAULT
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic [63:0] now,
  input  logic        sel,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        timer_clr
);
  localparam int CW = $clog2(CLR_CYCLES + 1);

  logic [63:0] now_s;
  logic [63:0] cmp_q, cmp_d;
  logic [31:0] period_q, period_d;
  logic [31:0] hi_snap_q, hi_snap_d;
  logic [31:0] rdata_q, rdata_d;
  logic [CW-1:0] clr_cnt_q, clr_cnt_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic        irq_q, irq_d;
  logic        timer_clr_q, timer_clr_d;
  logic        wr, rd, hit, reload;

  now_sampler u_sampler (
    .clk   (CLK100MHZ),
    .rst   (reset),
    .now   (now),
    .now_s (now_s)
  );

  always_comb begin
    wr        = sel & we;
    rd        = sel & ~we;
    hit       = ctrl_q.enable & (now_s >= cmp_q);
    reload    = hit & ctrl_q.periodic & (period_q != 32'd0);
    cmp_d     = cmp_q;
    ctrl_d    = ctrl_q;
    period_d  = period_q;
    hi_snap_d = hi_snap_q;
    rdata_d   = rdata_q;
    clr_cnt_d = (clr_cnt_q != '0) ? clr_cnt_q - 1'b1 : clr_cnt_q;

    if (reload) cmp_d = cmp_q + {32'b0, period_q};

    // A bus write to either compare half replaces the reload entirely
    if (wr) begin
      case (addr)
        ADDR_NOW_LO: clr_cnt_d = CW'(CLR_CYCLES);
        ADDR_CMP_LO: cmp_d = {cmp_q[63:32], wdata};
        ADDR_CMP_HI: cmp_d = {wdata, cmp_q[31:0]};
        ADDR_CTRL: begin
          ctrl_d.enable   = wdata[CTRL_EN];
          ctrl_d.periodic = wdata[CTRL_PER];
          if (wdata[CTRL_PEND]) ctrl_d.pending = 1'b0;
        end
        ADDR_PERIOD: period_d = wdata;
        default: ;
      endcase
    end
    if (hit) ctrl_d.pending = 1'b1;

    if (rd) begin
      case (addr)
        ADDR_NOW_LO: begin
          rdata_d   = now_s[31:0];
          hi_snap_d = now_s[63:32];
        end
        ADDR_NOW_HI: rdata_d = hi_snap_q;
        ADDR_CMP_LO: rdata_d = cmp_q[31:0];
        ADDR_CMP_HI: rdata_d = cmp_q[63:32];
        ADDR_CTRL:   rdata_d = {29'b0, ctrl_q.pending, ctrl_q.periodic, ctrl_q.enable};
        ADDR_PERIOD: rdata_d = period_q;
        default:     rdata_d = 32'd0;
      endcase
    end

    irq_d       = ctrl_q.pending & ctrl_q.enable;
    timer_clr_d = (clr_cnt_d != '0);
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      cmp_q       <= CMP_RESET;
      ctrl_q      <= '0;
      period_q    <= '0;
      hi_snap_q   <= '0;
      rdata_q     <= '0;
      clr_cnt_q   <= '0;
      irq_q       <= 1'b0;
      timer_clr_q <= 1'b0;
    end else begin
      cmp_q       <= cmp_d;
      ctrl_q      <= ctrl_d;
      period_q    <= period_d;
      hi_snap_q   <= hi_snap_d;
      rdata_q     <= rdata_d;
      clr_cnt_q   <= clr_cnt_d;
      irq_q       <= irq_d;
      timer_clr_q <= timer_clr_d;
    end
  end

  assign rdata     = rdata_q;
  assign irq       = irq_q;
  assign timer_clr = timer_clr_q;
endmodule

// File: tb/tb_timer_cmp_irq.sv
// Directed plus randomized checks of timer_cmp_irq; expected compare values come from closed-form arithmetic.
module tb_timer_cmp_irq;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] now;
  logic        sel, we;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq, timer_clr;

  int n_cmp = 0;
  int n_err = 0;

  timer_cmp_irq #(.CLR_CYCLES(2)) dut (
    .CLK100MHZ (clk),
    .reset     (reset),
    .now       (now),
    .sel       (sel),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .irq       (irq),
    .timer_clr (timer_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    sel = 1'b0;
    d = rdata;
  endtask

  // Drive now and keep it long enough for the filter to accept it
  task automatic set_now(input logic [63:0] v);
    now = v;
    hold(3);
  endtask

  initial begin
    logic [31:0] r;
    logic [63:0] snap;
    logic [63:0] cmp0, v, exp_cmp;
    int unsigned per, step, top;

    reset = 1'b1; now = '0; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    hold(2);
    chk("rst_irq", irq, 1'b0);
    chk("rst_clr", timer_clr, 1'b0);
    chk("rst_rdata", rdata, 32'd0);
    @(negedge clk) reset = 1'b0;

    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), r);
      chk($sformatf("rst_read_%0d", a), r, (a == 2 || a == 3) ? 32'hFFFF_FFFF : 32'd0);
    end

    // Tear-free 64-bit read: HI comes from the snapshot taken by the LO read
    set_now(64'h0000_0001_FFFF_FFF0);
    bus_read(3'd0, r);
    chk("snap_lo", r, 32'hFFFF_FFF0);
    set_now(64'h0000_0002_0000_0005);
    bus_read(3'd1, r);
    chk("snap_hi", r, 32'h0000_0001);
    for (int i = 0; i < 4; i++) begin
      snap = {$urandom, $urandom};
      set_now(snap);
      bus_read(3'd0, r);
      chk("rsnap_lo", r, snap[31:0]);
      set_now({$urandom, $urandom});
      bus_read(3'd1, r);
      chk("rsnap_hi", r, snap[63:32]);
    end

    // One-shot compare
    set_now(64'd0);
    bus_write(3'd3, 32'd0);
    bus_write(3'd2, 32'd100);
    bus_write(3'd4, 32'd1);
    for (int i = 95; i < 100; i++) set_now(64'(i));
    chk("os_irq_before", irq, 1'b0);
    now = 64'd100;
    hold(3);
    chk("os_irq_lat3", irq, 1'b0);
    hold(1);
    chk("os_irq_lat4", irq, 1'b1);
    for (int i = 101; i <= 105; i++) set_now(64'(i));
    bus_write(3'd4, 32'd5);
    bus_read(3'd4, r);
    chk("os_w1c_set_wins", r, 32'd5);
    bus_write(3'd2, 32'd1000);
    bus_write(3'd4, 32'd5);
    hold(2);
    chk("os_irq_cleared", irq, 1'b0);
    bus_read(3'd4, r);
    chk("os_ctrl_cleared", r, 32'd1);

    // Periodic compare
    bus_write(3'd4, 32'd4);
    set_now(64'd0);
    bus_write(3'd2, 32'd50);
    bus_write(3'd5, 32'd20);
    bus_write(3'd4, 32'd3);
    for (int i = 0; i <= 120; i++) begin
      set_now(64'(i));
      if (i >= 60 && i % 20 == 0) begin
        bus_read(3'd2, r);
        chk($sformatf("per_cmp_at_%0d", i), r, 32'(50 + 20 * ((i - 40) / 20)));
      end
    end
    bus_read(3'd4, r);
    chk("per_ctrl", r, 32'd7);
    bus_write(3'd5, 32'd0);
    for (int i = 121; i <= 140; i++) set_now(64'(i));
    bus_read(3'd2, r);
    chk("per0_cmp_held", r, 32'd130);

    // Clear pulse and restart mid-pulse
    bus_write(3'd0, 32'hDEAD_BEEF);
    chk("clr_c1", timer_clr, 1'b1);
    hold(1);
    chk("clr_c2", timer_clr, 1'b1);
    hold(1);
    chk("clr_c3", timer_clr, 1'b0);
    bus_write(3'd0, 32'd0);
    chk("clr2_c1", timer_clr, 1'b1);
    bus_write(3'd0, 32'd0);
    chk("clr2_c2", timer_clr, 1'b1);
    hold(1);
    chk("clr2_c3", timer_clr, 1'b1);
    hold(1);
    chk("clr2_c4", timer_clr, 1'b0);

    // One-cycle glitch on now must not reach now_s
    now = 64'd999;
    @(negedge clk) now = 64'd140;
    hold(3);
    bus_read(3'd0, r);
    chk("glitch_now_lo", r, 32'd140);

    // Reset in the middle of a clear pulse
    bus_write(3'd5, 32'd7);
    bus_write(3'd0, 32'd0);
    chk("rmid_clr_hi", timer_clr, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rmid_clr_drop", timer_clr, 1'b0);
    chk("rmid_irq", irq, 1'b0);
    chk("rmid_rdata", rdata, 32'd0);
    @(negedge clk) reset = 1'b0;
    bus_read(3'd5, r);
    chk("rmid_period", r, 32'd0);
    bus_read(3'd4, r);
    chk("rmid_ctrl", r, 32'd0);
    bus_read(3'd3, r);
    chk("rmid_cmp_hi", r, 32'hFFFF_FFFF);

    // Randomized periodic ramps; final cmp is the first cmp0 + k*per above the last now
    for (int it = 0; it < 3; it++) begin
      bus_write(3'd4, 32'd4);
      set_now(64'd0);
      cmp0 = 64'(100 + $urandom % 200);
      per  = 1 + $urandom % 50;
      top  = 200 + $urandom % 600;
      bus_write(3'd3, 32'd0);
      bus_write(3'd2, cmp0[31:0]);
      bus_write(3'd5, per);
      bus_write(3'd4, 32'd3);
      v = 0;
      while (v < 64'(top)) begin
        step = 1 + $urandom % per;
        v = v + 64'(step);
        set_now(v);
      end
      hold(4);
      exp_cmp = (v >= cmp0) ? cmp0 + ((v - cmp0) / 64'(per) + 1) * 64'(per) : cmp0;
      bus_read(3'd2, r);
      chk("rnd_cmp_lo", r, exp_cmp[31:0]);
      bus_read(3'd3, r);
      chk("rnd_cmp_hi", r, exp_cmp[63:32]);
      bus_read(3'd4, r);
      chk("rnd_ctrl", r, {29'b0, v >= cmp0, 2'b11});
      chk("rnd_irq", irq, v >= cmp0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
